// File: rtl/key_load_ctrl.sv
// Serial key loader: shifts a key word MSB-first into a shadow register and commits it
// to the XOR/MUX4 key-gate outputs. Optional even-parity check and lockout under `KEY_PARITY_EN.
module key_load_ctrl #(
  parameter int NXOR    = 17,
  parameter int NMUX    = 1,
  parameter int MAXFAIL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_in,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              abort,
  input  logic              clear,
  output logic [NXOR-1:0]   xor_key,
  output logic [4*NMUX-1:0] mux_key,
  output logic              key_loaded,
  output logic              load_done,
  output logic              load_err,
  output logic              locked_out
);

  localparam int KEYW = NXOR + 4 * NMUX;
`ifdef KEY_PARITY_EN
  localparam int NBITS = KEYW + 1;
  localparam int FW    = $clog2(MAXFAIL + 1);
`else
  localparam int NBITS = KEYW;
`endif
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  if (MAXFAIL < 1) begin : g_bad_maxfail
    $error("MAXFAIL must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_DONE
`ifdef KEY_PARITY_EN
    , S_LOCKOUT
`endif
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [NBITS-1:0]    shadow_q;
  logic [NBITS-1:0]    shadow_d;
  logic [KEYW-1:0]     key_word;
  logic [NXOR-1:0]     xor_q;
  logic [4*NMUX-1:0]   mux_q;
  logic                loaded_q;
  logic                done_q;
  logic                accept;
  logic                parity_ok;

  assign key_ready = (state_q == S_IDLE) || (state_q == S_SHIFT);
  assign accept    = key_valid && key_ready;
  assign shadow_d  = {shadow_q[NBITS-2:0], key_in};

  // With parity enabled the last shifted bit is the parity bit and sits below the key word.
`ifdef KEY_PARITY_EN
  assign key_word  = shadow_q[NBITS-1:1];
  assign parity_ok = ~(^shadow_q);
`else
  assign key_word  = shadow_q;
  assign parity_ok = 1'b1;
`endif

`ifdef KEY_PARITY_EN
  logic [FW-1:0] fail_q;
  logic          err_q;
  logic          lock_q;
  assign load_err   = err_q;
  assign locked_out = lock_q;
`else
  assign load_err   = 1'b0;
  assign locked_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      xor_q    <= '0;
      mux_q    <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef KEY_PARITY_EN
      fail_q   <= '0;
      err_q    <= 1'b0;
      lock_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef KEY_PARITY_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shadow_q <= {{(NBITS-1){1'b0}}, key_in};
            cnt_q    <= CW'(1);
            state_q  <= S_SHIFT;
          end
        end
        // abort outranks a bit arriving in the same cycle
        S_SHIFT: begin
          if (abort) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
          end else if (accept) begin
            shadow_q <= shadow_d;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= S_CHECK;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        S_CHECK: begin
          if (parity_ok) begin
            xor_q    <= key_word[KEYW-1:4*NMUX];
            mux_q    <= key_word[4*NMUX-1:0];
            loaded_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
`ifdef KEY_PARITY_EN
            fail_q   <= '0;
`endif
          end else begin
`ifdef KEY_PARITY_EN
            err_q    <= 1'b1;
            shadow_q <= '0;
            fail_q   <= fail_q + FW'(1);
            if (fail_q == FW'(MAXFAIL - 1)) begin
              lock_q  <= 1'b1;
              state_q <= S_LOCKOUT;
            end else begin
              state_q <= S_IDLE;
            end
`else
            state_q <= S_IDLE;
`endif
          end
        end
        S_DONE: begin
          if (clear) state_q <= S_IDLE;
        end
`ifdef KEY_PARITY_EN
        S_LOCKOUT: state_q <= S_LOCKOUT;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign xor_key    = xor_q;
  assign mux_key    = mux_q;
  assign key_loaded = loaded_q;
  assign load_done  = done_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed self-checking bench for key_load_ctrl at default parameters;
// parity/lockout scenarios run only when KEY_PARITY_EN is defined.
module tb_key_load_ctrl;
  localparam int NXOR = 17;
  localparam int NMUX = 1;
  localparam int KEYW = NXOR + 4 * NMUX;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              key_in = 1'b0;
  logic              key_valid = 1'b0;
  logic              abort = 1'b0;
  logic              clear = 1'b0;
  logic              key_ready;
  logic [NXOR-1:0]   xor_key;
  logic [4*NMUX-1:0] mux_key;
  logic              key_loaded;
  logic              load_done;
  logic              load_err;
  logic              locked_out;

  int checks = 0;
  int errors = 0;

  key_load_ctrl #(.NXOR(NXOR), .NMUX(NMUX), .MAXFAIL(3)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .abort(abort), .clear(clear),
    .xor_key(xor_key), .mux_key(mux_key), .key_loaded(key_loaded),
    .load_done(load_done), .load_err(load_err), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shifts the top nb bits of k MSB-first; a complete key also gets its parity bit when enabled.
  task automatic shift_key(input logic [KEYW-1:0] k, input int nb, input logic bad, input logic gap);
    for (int i = 0; i < nb; i++) begin
      if (gap && i > 0) step();
      key_in    = k[KEYW-1-i];
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
    end
`ifdef KEY_PARITY_EN
    if (nb == KEYW) begin
      if (gap) step();
      key_in    = (^k) ^ bad;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
    end
`endif
    key_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b1; key_in = 1'b1; abort = 1'b1; clear = 1'b1;
    step();
    step();
    checks++;
    if ({xor_key, mux_key, key_loaded, load_done, load_err, locked_out, key_ready} !== {21'h0, 5'b00001}) begin
      errors++;
      $display("[TB] FAIL reset_state got %h exp %h",
               {xor_key, mux_key, key_loaded, load_done, load_err, locked_out, key_ready}, {21'h0, 5'b00001});
    end
    rst = 1'b0; key_valid = 1'b0; key_in = 1'b0; abort = 1'b0; clear = 1'b0;
  endtask

  task automatic test_basic();
    shift_key(21'h1ABCD5, KEYW, 1'b0, 1'b0);
    checks++;
    if ({xor_key, mux_key, load_done, key_ready} !== {21'h0, 2'b00}) begin
      errors++;
      $display("[TB] FAIL basic_t1 got %h exp %h", {xor_key, mux_key, load_done, key_ready}, {21'h0, 2'b00});
    end
    step();
    checks++;
    if ({xor_key, mux_key, load_done, key_loaded, key_ready, load_err, locked_out} !== {21'h1ABCD5, 5'b11000}) begin
      errors++;
      $display("[TB] FAIL basic_t2 got %h exp %h",
               {xor_key, mux_key, load_done, key_loaded, key_ready, load_err, locked_out}, {21'h1ABCD5, 5'b11000});
    end
    step();
    checks++;
    if ({load_done, key_loaded} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL basic_pulse got %b exp %b", {load_done, key_loaded}, 2'b01);
    end
  endtask

  task automatic test_gaps_and_done();
    clear = 1'b1;
    step();
    clear = 1'b0;
    shift_key(21'h0A5A5C, KEYW, 1'b0, 1'b1);
    checks++;
    if ({key_ready, load_done, xor_key} !== {2'b00, 17'h1ABCD}) begin
      errors++;
      $display("[TB] FAIL gaps_check got %h exp %h", {key_ready, load_done, xor_key}, {2'b00, 17'h1ABCD});
    end
    step();
    checks++;
    if ({xor_key, mux_key, load_done, key_ready} !== {21'h0A5A5C, 2'b10}) begin
      errors++;
      $display("[TB] FAIL gaps_commit got %h exp %h", {xor_key, mux_key, load_done, key_ready}, {21'h0A5A5C, 2'b10});
    end
    // Extra bits and an abort while DONE must change nothing.
    key_valid = 1'b1; abort = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key_in = i[0];
      step();
    end
    key_valid = 1'b0; abort = 1'b0;
    checks++;
    if ({xor_key, mux_key, load_done, key_ready} !== {21'h0A5A5C, 2'b00}) begin
      errors++;
      $display("[TB] FAIL done_ignore got %h exp %h", {xor_key, mux_key, load_done, key_ready}, {21'h0A5A5C, 2'b00});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if ({xor_key, mux_key, key_loaded, key_ready} !== {21'h0A5A5C, 2'b11}) begin
      errors++;
      $display("[TB] FAIL clear_idle got %h exp %h", {xor_key, mux_key, key_loaded, key_ready}, {21'h0A5A5C, 2'b11});
    end
  endtask

  task automatic test_abort();
    shift_key(21'h1FFFFF, 10, 1'b0, 1'b0);
    checks++;
    if ({xor_key, mux_key, key_ready} !== {21'h0A5A5C, 1'b1}) begin
      errors++;
      $display("[TB] FAIL abort_midload got %h exp %h", {xor_key, mux_key, key_ready}, {21'h0A5A5C, 1'b1});
    end
    // Abort together with a valid bit: the bit must be dropped.
    abort = 1'b1; key_valid = 1'b1; key_in = 1'b1;
    step();
    abort = 1'b0; key_valid = 1'b0; key_in = 1'b0;
    shift_key(21'h000003, KEYW, 1'b0, 1'b0);
    checks++;
    if ({xor_key, mux_key, load_done, key_ready} !== {21'h0A5A5C, 2'b00}) begin
      errors++;
      $display("[TB] FAIL abort_reload_t1 got %h exp %h", {xor_key, mux_key, load_done, key_ready}, {21'h0A5A5C, 2'b00});
    end
    step();
    checks++;
    if ({xor_key, mux_key, load_done} !== {21'h000003, 1'b1}) begin
      errors++;
      $display("[TB] FAIL abort_reload_t2 got %h exp %h", {xor_key, mux_key, load_done}, {21'h000003, 1'b1});
    end
  endtask

  task automatic test_reset_mid_shift();
    clear = 1'b1;
    step();
    clear = 1'b0;
    shift_key(21'h1FFFFF, 7, 1'b0, 1'b0);
    rst = 1'b1; key_valid = 1'b1; key_in = 1'b1;
    step();
    rst = 1'b0; key_valid = 1'b0; key_in = 1'b0;
    checks++;
    if ({xor_key, mux_key, key_loaded, load_done, load_err, locked_out, key_ready} !== {21'h0, 5'b00001}) begin
      errors++;
      $display("[TB] FAIL rst_midshift got %h exp %h",
               {xor_key, mux_key, key_loaded, load_done, load_err, locked_out, key_ready}, {21'h0, 5'b00001});
    end
    shift_key(21'h1ABCD5, KEYW, 1'b0, 1'b0);
    checks++;
    if ({key_ready, load_done, key_loaded} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_reload_t1 got %b exp %b", {key_ready, load_done, key_loaded}, 3'b000);
    end
    step();
    checks++;
    if ({xor_key, mux_key, load_done, key_loaded} !== {21'h1ABCD5, 2'b11}) begin
      errors++;
      $display("[TB] FAIL rst_reload_t2 got %h exp %h", {xor_key, mux_key, load_done, key_loaded}, {21'h1ABCD5, 2'b11});
    end
  endtask

`ifdef KEY_PARITY_EN
  task automatic test_parity_lockout();
    do_reset();
    shift_key(21'h1ABCD5, KEYW, 1'b0, 1'b0);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift_key(21'h000003, KEYW, 1'b1, 1'b0);
      step();
      checks++;
      if ({xor_key, mux_key, load_err, load_done, locked_out, key_ready} !== {21'h1ABCD5, 2'b10, (i == 2), (i != 2)}) begin
        errors++;
        $display("[TB] FAIL bad_parity_%0d got %h exp %h", i,
                 {xor_key, mux_key, load_err, load_done, locked_out, key_ready}, {21'h1ABCD5, 2'b10, (i == 2), (i != 2)});
      end
    end
    clear = 1'b1; abort = 1'b1; key_valid = 1'b1;
    step(); step(); step();
    clear = 1'b0; abort = 1'b0; key_valid = 1'b0;
    checks++;
    if ({locked_out, key_ready, load_err, xor_key} !== {3'b100, 17'h1ABCD}) begin
      errors++;
      $display("[TB] FAIL lockout_hold got %h exp %h", {locked_out, key_ready, load_err, xor_key}, {3'b100, 17'h1ABCD});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({locked_out, key_ready, key_loaded} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL lockout_rst got %b exp %b", {locked_out, key_ready, key_loaded}, 3'b010);
    end
  endtask

  task automatic test_parity_recover();
    do_reset();
    shift_key(21'h1ABCD5, KEYW, 1'b1, 1'b0);
    step();
    checks++;
    if ({load_err, key_loaded, key_ready} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL recover_bad got %b exp %b", {load_err, key_loaded, key_ready}, 3'b101);
    end
    shift_key(21'h000003, KEYW, 1'b0, 1'b0);
    step();
    checks++;
    if ({xor_key, mux_key, load_done, load_err} !== {21'h000003, 2'b10}) begin
      errors++;
      $display("[TB] FAIL recover_good got %h exp %h", {xor_key, mux_key, load_done, load_err}, {21'h000003, 2'b10});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      shift_key(21'h1ABCD5, KEYW, 1'b1, 1'b0);
      step();
      checks++;
      if ({load_err, locked_out, key_ready, mux_key} !== {3'b101, 4'h3}) begin
        errors++;
        $display("[TB] FAIL recover_nolock_%0d got %h exp %h", i, {load_err, locked_out, key_ready, mux_key}, {3'b101, 4'h3});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps_and_done();
    test_abort();
    test_reset_mid_shift();
`ifdef KEY_PARITY_EN
    test_parity_lockout();
    test_parity_recover();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
